fifo_wr_arbiter: RTL and testbench

- Shares the single write port of the synchronous FIFO between NUM_REQ producers.
- Grants are round-robin with a bounded burst length per grant.
- Tracks FIFO free space with a credit counter, so the FIFO never sees a write while it has no room.
- Sits between the producer blocks and the FIFO DUT's wr_en/data_in inputs; observes the FIFO read side to return credits.

---
 rtl/fifo_wr_arbiter_pkg.sv | 17 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared constants and types for the FIFO write-port arbiter.
//   FIFO_WIDTH / FIFO_DEPTH : FIFO data width and capacity in words
//   NUM_REQ / MAX_BURST     : default requester count and burst length
//   arb_state_e             : arbiter FSM state encoding
package fifo_wr_arbiter_pkg;

  localparam int unsigned FIFO_WIDTH = 16;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned MAX_BURST  = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req_i        : request vector
//   last_owner_i : index granted most recently; scanning starts just above it
//   idx_o        : first requesting index found, wrapping at NUM_REQ
//   valid_o      : at least one request is set
module fifo_wr_arbiter_rr_pick #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_owner_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  // Scan last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ); first hit wins.
  always_comb begin
    int unsigned j;
    logic [IDX_W-1:0] cand;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      j = 32'(last_owner_i) + k;
      if (j >= NUM_REQ) begin
        j = j - NUM_REQ;
      end
      cand = IDX_W'(j);
      if (!valid_o && req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Bursts of up to MAX_BURST words per grant; a credit counter mirrors FIFO
// free space so no write is issued while the FIFO has no room.
//   clk, rst                : clock, synchronous active-high reset
//   req, req_data           : per-requester word-available and packed data
//   gnt                     : one-hot grant (combinational from registers)
//   wr_en, data_in          : registered FIFO write port
//   fifo_rd_en, fifo_empty  : FIFO read side, used to return credits
//   fifo_overflow           : FIFO overflow flag, folded into err
//   credit                  : free FIFO slots as tracked here
//   busy                    : arbiter is in a burst
//   err                     : sticky error (overflow or credit saturation)
module fifo_wr_arbiter #(
  parameter  int unsigned NUM_REQ    = fifo_wr_arbiter_pkg::NUM_REQ,
  parameter  int unsigned MAX_BURST  = fifo_wr_arbiter_pkg::MAX_BURST,
  parameter  int unsigned FIFO_WIDTH = fifo_wr_arbiter_pkg::FIFO_WIDTH,
  parameter  int unsigned FIFO_DEPTH = fifo_wr_arbiter_pkg::FIFO_DEPTH,
  localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [FIFO_WIDTH-1:0]         data_in,
  input  logic                          fifo_rd_en,
  input  logic                          fifo_empty,
  input  logic                          fifo_overflow,
  output logic [CW-1:0]                 credit,
  output logic                          busy,
  output logic                          err
);

  import fifo_wr_arbiter_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned BW    = $clog2(MAX_BURST + 1);

  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0]    LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_owner_q, last_owner_d;
  logic [BW-1:0]           burst_cnt_q, burst_cnt_d;
  logic [CW-1:0]           credit_q, credit_d;
  logic                    wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]   data_q, data_d;
  logic                    err_q, err_d;

  logic [FIFO_WIDTH-1:0]   req_word [NUM_REQ];
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_valid;
  logic                    credit_ok;
  logic                    accept;
  logic                    rd_done;
  logic                    saturate;

  // Unpack requester data slices.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
  end

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .req_i        (req),
    .last_owner_i (last_owner_q),
    .idx_o        (pick_idx),
    .valid_o      (pick_valid)
  );

  assign credit_ok = (credit_q != '0);
  assign gnt       = (state_q == ARB_BURST && credit_ok) ? (NUM_REQ'(1) << owner_q) : '0;
  assign accept    = req[owner_q] & gnt[owner_q];
  assign rd_done   = fifo_rd_en & ~fifo_empty;

  // Next-state, credit and write-path logic.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    credit_d     = credit_q;
    saturate     = 1'b0;
    wr_en_d      = accept;
    data_d       = accept ? req_word[owner_q] : data_q;

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid && credit_ok) begin
          state_d      = ARB_BURST;
          owner_d      = pick_idx;
          last_owner_d = pick_idx;
          burst_cnt_d  = '0;
        end
      end
      ARB_BURST: begin
        // A credit stall leaves accept low with req high: state and count hold.
        if (accept) begin
          if (burst_cnt_q == LAST_BEAT) begin
            state_d     = ARB_IDLE;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end else if (!req[owner_q]) begin
          state_d     = ARB_IDLE;
          burst_cnt_d = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    // Simultaneous accept and read leave the credit unchanged.
    case ({accept, rd_done})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == DEPTH_C) begin
          saturate = 1'b1;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: credit_d = credit_q;
    endcase

    err_d = err_q | fifo_overflow | saturate;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      burst_cnt_q  <= '0;
      credit_q     <= DEPTH_C;
      wr_en_q      <= 1'b0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      credit_q     <= credit_d;
      wr_en_q      <= wr_en_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign data_in = data_q;
  assign credit  = credit_q;
  assign busy    = (state_q == ARB_BURST);
  assign err     = err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter with a behavioural FIFO and
// counting producers (requester i offers {i+1, n} for its n-th word).
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 16;
  localparam int CW = 4;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*W-1:0]   req_data;
  logic [NR-1:0]     gnt;
  logic              wr_en;
  logic [W-1:0]      data_in;
  logic              fifo_rd_en;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic [CW-1:0]     credit;
  logic              busy;
  logic              err;

  logic              fifo_empty_m;
  logic              spoof;
  int                quota [NR];
  int                nxt   [NR];
  int                acc_log [$];
  logic [W-1:0]      wr_log [$];
  logic [W-1:0]      rd_log [$];
  logic [W-1:0]      fq [$];

  int checks;
  int failures;

  fifo_wr_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .wr_en         (wr_en),
    .data_in       (data_in),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_empty    (fifo_empty),
    .fifo_overflow (fifo_overflow),
    .credit        (credit),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_empty = fifo_empty_m & ~spoof;

  // Producers: request while below quota, offer the next numbered word.
  always_comb begin
    req      = '0;
    req_data = '0;
    for (int i = 0; i < NR; i++) begin
      req[i]            = (nxt[i] < quota[i]);
      req_data[i*W +: W] = {4'(i + 1), 12'(nxt[i])};
    end
  end

  // Producer counters, FIFO model and logs.
  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      acc_log.delete();
      wr_log.delete();
      rd_log.delete();
      fifo_empty_m <= 1'b1;
      for (int i = 0; i < NR; i++) nxt[i] <= 0;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (req[i] && gnt[i]) begin
          nxt[i] <= nxt[i] + 1;
          acc_log.push_back(i);
        end
      end
      if (fifo_rd_en && !fifo_empty && fq.size() > 0) rd_log.push_back(fq.pop_front());
      if (wr_en) begin
        fq.push_back(data_in);
        wr_log.push_back(data_in);
      end
      fifo_empty_m <= (fq.size() == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic adv(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    fifo_rd_en    = 1'b0;
    fifo_overflow = 1'b0;
    spoof         = 1'b0;
    for (int i = 0; i < NR; i++) quota[i] = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic         rd;
    logic [3:0]   gnt;
    logic         busy;
    logic         wr;
    logic [3:0]   cr;
    logic [15:0]  data;
  } vec_t;

  vec_t         tbl [13];
  int           exp_acc [$];
  logic [W-1:0] exp_dat [$];
  int           exp3 [8];
  int           mincr;
  int           n1;

  initial begin
    begin : watchdog
      fork
        begin
          #200000;
          $display("FAIL watchdog actual=timeout expected=finish");
          $fatal(1, "watchdog");
        end
      join_none
    end

    checks   = 0;
    failures = 0;

    // Single requester, no reads: per-cycle expectations from c0.
    tbl[0]  = '{1'b0, 4'h0, 1'b0, 1'b0, 4'd8, 16'h0000};
    tbl[1]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'd8, 16'h0000};
    tbl[2]  = '{1'b0, 4'h1, 1'b1, 1'b1, 4'd7, 16'h1000};
    tbl[3]  = '{1'b0, 4'h1, 1'b1, 1'b1, 4'd6, 16'h1001};
    tbl[4]  = '{1'b0, 4'h1, 1'b1, 1'b1, 4'd5, 16'h1002};
    tbl[5]  = '{1'b0, 4'h0, 1'b0, 1'b1, 4'd4, 16'h1003};
    tbl[6]  = '{1'b0, 4'h1, 1'b1, 1'b0, 4'd4, 16'h1003};
    tbl[7]  = '{1'b0, 4'h1, 1'b1, 1'b1, 4'd3, 16'h1004};
    tbl[8]  = '{1'b0, 4'h1, 1'b1, 1'b1, 4'd2, 16'h1005};
    tbl[9]  = '{1'b0, 4'h1, 1'b1, 1'b1, 4'd1, 16'h1006};
    tbl[10] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'd0, 16'h1007};
    tbl[11] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'h1007};
    tbl[12] = '{1'b0, 4'h0, 1'b0, 1'b0, 4'd0, 16'h1007};

    // Reset state.
    do_reset();
    chk("rst_gnt",    32'(gnt),     32'h0);
    chk("rst_busy",   32'(busy),    32'h0);
    chk("rst_credit", 32'(credit),  32'd8);
    chk("rst_wr_en",  32'(wr_en),   32'h0);
    chk("rst_data",   32'(data_in), 32'h0);
    chk("rst_err",    32'(err),     32'h0);

    // Test 1: single requester until the FIFO is full.
    quota[0] = 100;
    for (int r = 0; r < 13; r++) begin
      if (r > 0) step();
      fifo_rd_en = tbl[r].rd;
      chk($sformatf("t1_gnt[%0d]", r),    32'(gnt),     32'(tbl[r].gnt));
      chk($sformatf("t1_busy[%0d]", r),   32'(busy),    32'(tbl[r].busy));
      chk($sformatf("t1_wr_en[%0d]", r),  32'(wr_en),   32'(tbl[r].wr));
      chk($sformatf("t1_credit[%0d]", r), 32'(credit),  32'(tbl[r].cr));
      chk($sformatf("t1_data[%0d]", r),   32'(data_in), 32'(tbl[r].data));
    end
    chk("t1_wr_count", 32'(wr_log.size()), 32'd8);
    chk("t1_fifo_fill", 32'(fq.size()), 32'd8);
    chk("t1_err", 32'(err), 32'h0);
    if (wr_log.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("t1_word[%0d]", k), 32'(wr_log[k]), 32'h1000 + 32'(k));

    // Test 2: all requesting, consumer reads every cycle.
    do_reset();
    quota[0] = 8; quota[1] = 4; quota[2] = 4; quota[3] = 4;
    fifo_rd_en = 1'b1;
    exp_acc.delete();
    exp_dat.delete();
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 4; w++) begin
        exp_acc.push_back(k % 4);
        exp_dat.push_back({4'((k % 4) + 1), 12'(((k == 4) ? 4 : 0) + w)});
      end
    end
    mincr = 8;
    for (int c = 0; c < 40; c++) begin
      step();
      if (int'(credit) < mincr) mincr = int'(credit);
    end
    chk("t2_acc_count", 32'(acc_log.size()), 32'd20);
    chk("t2_rd_count",  32'(rd_log.size()),  32'd20);
    if (acc_log.size() == 20 && wr_log.size() == 20 && rd_log.size() == 20) begin
      for (int k = 0; k < 20; k++) begin
        chk($sformatf("t2_owner[%0d]", k), 32'(acc_log[k]), 32'(exp_acc[k]));
        chk($sformatf("t2_wr[%0d]", k),    32'(wr_log[k]),  32'(exp_dat[k]));
        chk($sformatf("t2_rd[%0d]", k),    32'(rd_log[k]),  32'(exp_dat[k]));
      end
    end
    chk("t2_min_credit", 32'(mincr), 32'd6);
    chk("t2_end_credit", 32'(credit), 32'd8);
    chk("t2_err", 32'(err), 32'h0);

    // Test 3: owner drops req after two words; burst count restarts.
    do_reset();
    quota[0] = 2; quota[1] = 6;
    adv(3);
    chk("t3_c3_busy", 32'(busy), 32'h1);
    chk("t3_c3_gnt",  32'(gnt),  32'h1);
    adv(1);
    chk("t3_c4_busy", 32'(busy), 32'h0);
    chk("t3_c4_gnt",  32'(gnt),  32'h0);
    adv(1);
    chk("t3_c5_gnt",  32'(gnt),  32'h2);
    adv(3);
    chk("t3_c8_gnt",  32'(gnt),  32'h2);
    adv(1);
    chk("t3_c9_busy", 32'(busy), 32'h0);
    adv(1);
    chk("t3_c10_gnt", 32'(gnt),  32'h2);
    adv(6);
    exp3 = '{0, 0, 1, 1, 1, 1, 1, 1};
    chk("t3_acc_count", 32'(acc_log.size()), 32'd8);
    if (acc_log.size() == 8)
      for (int k = 0; k < 8; k++) chk($sformatf("t3_owner[%0d]", k), 32'(acc_log[k]), 32'(exp3[k]));

    // Test 4: credit 1, accept and read together keep credit at 1.
    do_reset();
    quota[0] = 7;
    adv(10);
    chk("t4_c10_busy",   32'(busy),   32'h0);
    chk("t4_c10_credit", 32'(credit), 32'd1);
    quota[1] = 3;
    for (int c = 11; c <= 13; c++) begin
      step();
      fifo_rd_en = 1'b1;
      chk($sformatf("t4_gnt[c%0d]", c),    32'(gnt),    32'h2);
      chk($sformatf("t4_credit[c%0d]", c), 32'(credit), 32'd1);
    end
    step();
    fifo_rd_en = 1'b0;
    chk("t4_c14_credit", 32'(credit), 32'd1);
    n1 = 0;
    foreach (acc_log[k]) if (acc_log[k] == 1) n1++;
    chk("t4_req1_words", 32'(n1), 32'd3);

    // Test 5: credit stall mid-burst, resume at the held burst count.
    do_reset();
    quota[0] = 6;
    adv(9);
    chk("t5_c9_credit", 32'(credit), 32'd2);
    quota[1] = 10;
    adv(1);
    chk("t5_c10_gnt", 32'(gnt), 32'h2);
    adv(2);
    chk("t5_c12_gnt",    32'(gnt),    32'h0);
    chk("t5_c12_busy",   32'(busy),   32'h1);
    chk("t5_c12_credit", 32'(credit), 32'd0);
    adv(2);
    chk("t5_c14_gnt",  32'(gnt),  32'h0);
    chk("t5_c14_busy", 32'(busy), 32'h1);
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    chk("t5_c15_credit", 32'(credit), 32'd1);
    chk("t5_c15_gnt",    32'(gnt),    32'h2);
    step();
    chk("t5_c16_gnt",  32'(gnt),  32'h0);
    chk("t5_c16_busy", 32'(busy), 32'h1);
    fifo_rd_en = 1'b1;
    step();
    fifo_rd_en = 1'b0;
    chk("t5_c17_gnt", 32'(gnt), 32'h2);
    step();
    chk("t5_c18_busy",   32'(busy),   32'h0);
    chk("t5_c18_credit", 32'(credit), 32'd0);
    chk("t5_err",        32'(err),    32'h0);

    // Test 6: reset mid-burst after two words.
    do_reset();
    quota[0] = 10; quota[1] = 10;
    adv(3);
    chk("t6_c3_wr_en", 32'(wr_en),   32'h1);
    chk("t6_c3_data",  32'(data_in), 32'h1001);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_c4_gnt",    32'(gnt),     32'h0);
    chk("t6_c4_credit", 32'(credit),  32'd8);
    chk("t6_c4_wr_en",  32'(wr_en),   32'h0);
    chk("t6_c4_busy",   32'(busy),    32'h0);
    chk("t6_c4_data",   32'(data_in), 32'h0);
    step();
    chk("t6_c5_gnt", 32'(gnt), 32'h1);

    // Test 7: credit saturation and FIFO overflow set the sticky error.
    do_reset();
    spoof      = 1'b1;
    fifo_rd_en = 1'b1;
    step();
    spoof      = 1'b0;
    fifo_rd_en = 1'b0;
    chk("t7_sat_credit", 32'(credit), 32'd8);
    chk("t7_sat_err",    32'(err),    32'h1);
    step();
    chk("t7_sat_sticky", 32'(err), 32'h1);
    do_reset();
    chk("t7_rst_err", 32'(err), 32'h0);
    fifo_overflow = 1'b1;
    step();
    fifo_overflow = 1'b0;
    chk("t7_ovf_err", 32'(err), 32'h1);
    adv(2);
    chk("t7_ovf_sticky", 32'(err),    32'h1);
    chk("t7_ovf_credit", 32'(credit), 32'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
